// File: rtl/vq_codebook_fetch.sv
// Burst-reads the 256-entry, 64-bit VQ codebook from VRAM and streams each word
// to the codebook cache as a registered one-cycle strobe, one burst outstanding at a time.
module vq_codebook_fetch #(
    parameter int BURST_LEN = 8,
    parameter int ADDR_W    = 20
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] cb_base,
    input  logic              codebook_wait,
    input  logic [7:0]        ram_read_offset,
    output logic              cache_vram_valid,
    output logic [63:0]       cache_din,
    output logic              vram_rd,
    output logic [ADDR_W-1:0] vram_addr,
    input  logic              vram_ack,
    input  logic              vram_rvalid,
    input  logic [63:0]       vram_rdata,
    output logic              fetch_busy,
    output logic              seq_error
);

    localparam int                BEAT_W    = $clog2(BURST_LEN) + 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [8:0]        CB_WORDS  = 9'd256;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_DATA,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [ADDR_W-1:0]   r_base;
    logic [8:0]          r_wcnt;
    logic [BEAT_W-1:0]   r_beat;
    logic                r_valid;
    logic [63:0]         r_din;
    logic                r_seq_error;
    logic                r_busy;

    logic                w_start;
    logic                w_last_beat;
    logic                w_deliver;
    logic                w_swallow;
    logic [8:0]          w_wcnt_inc;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        w_last_beat  = (r_beat == LAST_BEAT);
        w_wcnt_inc   = r_wcnt + 9'd1;
        w_start      = (r_state == S_IDLE) && codebook_wait;
        // A beat coinciding with the request falling is only delivered if it closes the burst.
        w_deliver    = (r_state == S_DATA) && vram_rvalid && (codebook_wait || w_last_beat);
        w_swallow    = vram_rvalid &&
                       ((r_state == S_DRAIN) || ((r_state == S_DATA) && !w_deliver));
        w_next_state = r_state;

        case (r_state)
            S_IDLE: begin
                if (codebook_wait) begin
                    w_next_state = S_REQ;
                end
            end
            S_REQ: begin
                if (vram_ack) begin
                    w_next_state = S_DATA;
                end else if (!codebook_wait) begin
                    w_next_state = S_IDLE;
                end
            end
            S_DATA: begin
                if (w_deliver && w_last_beat) begin
                    if (w_wcnt_inc == CB_WORDS) begin
                        w_next_state = S_DONE;
                    end else if (codebook_wait) begin
                        w_next_state = S_REQ;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end else if (!codebook_wait) begin
                    w_next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (vram_rvalid && w_last_beat) begin
                    w_next_state = S_IDLE;
                end
            end
            S_DONE: begin
                if (!codebook_wait) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_base      <= '0;
            r_wcnt      <= '0;
            r_beat      <= '0;
            r_valid     <= 1'b0;
            r_din       <= '0;
            r_seq_error <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_busy  <= (r_state != S_IDLE);
            r_valid <= w_deliver;

            if (w_start) begin
                r_base <= cb_base;
                r_wcnt <= '0;
            end

            if ((r_state == S_REQ) && vram_ack) begin
                r_beat <= '0;
            end else if (w_deliver || w_swallow) begin
                r_beat <= r_beat + BEAT_W'(1);
            end

            if (w_deliver) begin
                r_din  <= vram_rdata;
                r_wcnt <= w_wcnt_inc;
                if (ram_read_offset != r_wcnt[7:0]) begin
                    r_seq_error <= 1'b1;
                end
            end
        end
    end

    // The address is gated to zero outside REQ so the port is quiet while idle.
    assign vram_rd          = (r_state == S_REQ);
    assign vram_addr        = vram_rd ? (r_base + ADDR_W'(r_wcnt)) : '0;
    assign cache_vram_valid = r_valid;
    assign cache_din        = r_din;
    assign fetch_busy       = r_busy;
    assign seq_error        = r_seq_error;

endmodule

// File: tb/tb_vq_codebook_fetch.sv
// Directed bench for vq_codebook_fetch: a cycle-stepped VRAM responder and cache
// monitor run inside tick(); full fills are table-driven, corner cases are hand sequences.
module tb_vq_codebook_fetch;

    localparam int AW = 20;
    localparam int BL = 8;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [AW-1:0] cb_base = '0;
    logic          codebook_wait = 1'b0;
    logic [7:0]    ram_read_offset = '0;
    logic          cache_vram_valid;
    logic [63:0]   cache_din;
    logic          vram_rd;
    logic [AW-1:0] vram_addr;
    logic          vram_ack = 1'b0;
    logic          vram_rvalid = 1'b0;
    logic [63:0]   vram_rdata = '0;
    logic          fetch_busy;
    logic          seq_error;

    vq_codebook_fetch #(.BURST_LEN(BL), .ADDR_W(AW)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .cb_base          (cb_base),
        .codebook_wait    (codebook_wait),
        .ram_read_offset  (ram_read_offset),
        .cache_vram_valid (cache_vram_valid),
        .cache_din        (cache_din),
        .vram_rd          (vram_rd),
        .vram_addr        (vram_addr),
        .vram_ack         (vram_ack),
        .vram_rvalid      (vram_rvalid),
        .vram_rdata       (vram_rdata),
        .fetch_busy       (fetch_busy),
        .seq_error        (seq_error)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [AW-1:0] base;
        int            ack_dly;
        bit            gap;
        int            bad_off_at;
        logic [AW-1:0] exp_addr0;
        logic [AW-1:0] exp_addr1;
        logic [63:0]   exp_last_din;
        logic          exp_seq;
    } vec_t;

    vec_t vecs [4];

    int            n_checks = 0;
    int            n_fail = 0;

    // responder: 0 idle, 1 waiting to ack, 2 sending beats
    int            m_state = 0;
    int            m_cnt = 0;
    int            m_beat = 0;
    bit            m_skip = 1'b0;
    logic [AW-1:0] m_addr = '0;
    int            cfg_ack_dly = 1;
    bit            cfg_gap = 1'b0;
    int            cfg_bad_off_at = -1;

    logic [AW-1:0] fill_base = '0;
    int            strobe_cnt = 0;
    int            din_bad = 0;
    int            req_cnt = 0;
    int            req_bad = 0;
    int            hold_bad = 0;
    int            extra_rd = 0;
    int            idle_bad = 0;
    logic [AW-1:0] req_addr0 = '0;
    logic [AW-1:0] req_addr1 = '0;
    logic [63:0]   last_din = '0;
    logic          seq_at3 = 1'b0;
    logic          seq_at4 = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: observe the cache side, then let the VRAM model drive the next cycle.
    task automatic tick();
        logic [AW-1:0] exp_word;
        @(posedge clock);
        #1;
        if (cache_vram_valid) begin
            exp_word = fill_base + AW'(strobe_cnt);
            if (cache_din !== {{(64-AW){1'b0}}, exp_word}) din_bad++;
            if (strobe_cnt == 3) seq_at3 = seq_error;
            if (strobe_cnt == 4) seq_at4 = seq_error;
            last_din = cache_din;
            strobe_cnt++;
        end
        ram_read_offset = (strobe_cnt == cfg_bad_off_at) ? 8'(strobe_cnt + 1) : 8'(strobe_cnt);

        vram_ack    = 1'b0;
        vram_rvalid = 1'b0;
        case (m_state)
            0: begin
                if (vram_rd) begin
                    if (req_cnt == 0) req_addr0 = vram_addr;
                    if (req_cnt == 1) req_addr1 = vram_addr;
                    if (vram_addr !== fill_base + AW'(req_cnt * BL)) req_bad++;
                    req_cnt++;
                    m_addr  = vram_addr;
                    m_cnt   = cfg_ack_dly;
                    m_state = 1;
                end
            end
            1: begin
                if (!vram_rd) begin
                    m_state = 0;
                end else begin
                    if (vram_addr !== m_addr) hold_bad++;
                    m_cnt--;
                    if (m_cnt == 0) begin
                        vram_ack = 1'b1;
                        m_beat   = 0;
                        m_skip   = cfg_gap;
                        m_state  = 2;
                    end
                end
            end
            default: begin
                if (vram_rd) extra_rd++;
                if (m_skip) begin
                    m_skip = 1'b0;
                end else begin
                    vram_rvalid = 1'b1;
                    vram_rdata  = {{(64-AW){1'b0}}, m_addr + AW'(m_beat)};
                    m_beat++;
                    m_skip = cfg_gap;
                    if (m_beat == BL) m_state = 0;
                end
            end
        endcase
    endtask

    task automatic do_reset(input string tag);
        codebook_wait = 1'b0;
        reset_n       = 1'b0;
        vram_ack      = 1'b0;
        vram_rvalid   = 1'b0;
        vram_rdata    = '0;
        m_state       = 0;
        repeat (2) @(posedge clock);
        #1;
        check({tag, "_rst_ctrl"}, {vram_rd, cache_vram_valid, fetch_busy, seq_error}, 0);
        check({tag, "_rst_addr"}, vram_addr, 0);
        check({tag, "_rst_din"}, cache_din, 0);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic start_fill(input logic [AW-1:0] base, input int dly, input bit gap, input int bad_at);
        cfg_ack_dly    = dly;
        cfg_gap        = gap;
        cfg_bad_off_at = bad_at;
        fill_base      = base;
        strobe_cnt     = 0;
        din_bad        = 0;
        req_cnt        = 0;
        req_bad        = 0;
        hold_bad       = 0;
        extra_rd       = 0;
        seq_at3        = 1'b0;
        seq_at4        = 1'b0;
        ram_read_offset = '0;
        cb_base        = base;
        codebook_wait  = 1'b1;
    endtask

    // Bounded wait; the final comparison doubles as the timeout report.
    task automatic run_until_strobes(input int target, input int budget, input string name);
        int n = 0;
        while (strobe_cnt < target && n < budget) begin
            tick();
            n++;
        end
        check(name, strobe_cnt, target);
    endtask

    initial begin
        vecs[0] = '{20'h01000, 1, 1'b0, -1, 20'h01000, 20'h01008, 64'h010FF, 1'b0};
        vecs[1] = '{20'h01000, 5, 1'b1, -1, 20'h01000, 20'h01008, 64'h010FF, 1'b0};
        vecs[2] = '{20'hFFFF8, 1, 1'b0, -1, 20'hFFFF8, 20'h00000, 64'h000F7, 1'b0};
        vecs[3] = '{20'h00400, 2, 1'b0,  4, 20'h00400, 20'h00408, 64'h004FF, 1'b1};

        for (int i = 0; i < 4; i++) begin
            string t;
            t = $sformatf("row%0d", i);
            do_reset(t);
            start_fill(vecs[i].base, vecs[i].ack_dly, vecs[i].gap, vecs[i].bad_off_at);
            tick();
            check({t, "_busy_lag"}, fetch_busy, 0);
            tick();
            check({t, "_busy_on"}, fetch_busy, 1);
            run_until_strobes(256, 3000, {t, "_strobes"});
            repeat (4) tick();
            check({t, "_req_count"}, req_cnt, 32);
            check({t, "_done_busy"}, fetch_busy, 1);
            check({t, "_addr0"}, req_addr0, vecs[i].exp_addr0);
            check({t, "_addr1"}, req_addr1, vecs[i].exp_addr1);
            check({t, "_last_din"}, last_din, vecs[i].exp_last_din);
            check({t, "_din_order"}, din_bad, 0);
            check({t, "_req_addrs"}, req_bad, 0);
            check({t, "_req_hold"}, hold_bad, 0);
            check({t, "_one_outstanding"}, extra_rd, 0);
            check({t, "_seq_before"}, seq_at3, 0);
            check({t, "_seq_at_beat4"}, seq_at4, vecs[i].exp_seq);
            check({t, "_seq_final"}, seq_error, vecs[i].exp_seq);
            codebook_wait = 1'b0;
            repeat (2) tick();
            check({t, "_idle_busy"}, fetch_busy, 0);
            check({t, "_no_extra_strobes"}, strobe_cnt, 256);
        end

        // Abort after beat 3 of burst 2, then a fresh fill from a new base.
        do_reset("abort");
        start_fill(20'h01000, 1, 1'b0, -1);
        run_until_strobes(11, 500, "abort_pre_strobes");
        codebook_wait = 1'b0;
        repeat (20) tick();
        check("abort_swallowed", strobe_cnt, 11);
        check("abort_req_count", req_cnt, 2);
        check("abort_busy", fetch_busy, 0);
        check("abort_rd", vram_rd, 0);
        start_fill(20'h02000, 1, 1'b0, -1);
        run_until_strobes(256, 3000, "refill_strobes");
        check("refill_addr0", req_addr0, 20'h02000);
        check("refill_din_order", din_bad, 0);
        check("refill_last_din", last_din, 64'h020FF);
        check("refill_seq", seq_error, 0);
        codebook_wait = 1'b0;
        repeat (2) tick();

        // Reset mid-burst; stray beats from the responder must be ignored.
        do_reset("rstmid");
        start_fill(20'h03000, 1, 1'b0, -1);
        run_until_strobes(5, 200, "rstmid_pre_strobes");
        #2;
        reset_n       = 1'b0;
        codebook_wait = 1'b0;
        #1;
        check("rstmid_ctrl", {vram_rd, cache_vram_valid, fetch_busy, seq_error}, 0);
        check("rstmid_addr", vram_addr, 0);
        check("rstmid_din", cache_din, 0);
        tick();
        @(negedge clock);
        reset_n  = 1'b1;
        idle_bad = 0;
        repeat (15) begin
            tick();
            if (vram_rd || fetch_busy) idle_bad++;
        end
        check("rstmid_no_strobes", strobe_cnt, 5);
        check("rstmid_stays_idle", idle_bad, 0);

        // New request after reset, withdrawn before the arbiter acks.
        fill_base     = 20'h05000;
        req_cnt       = 0;
        cb_base       = 20'h05000;
        codebook_wait = 1'b1;
        tick();
        check("rstmid_req_rd", vram_rd, 1);
        check("rstmid_req_addr", vram_addr, 20'h05000);
        codebook_wait = 1'b0;
        tick();
        check("req_abort_rd", vram_rd, 0);
        repeat (2) tick();
        check("req_abort_busy", fetch_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/vq_codebook_fetch.md
Name: vq_codebook_fetch

Overview:
- Upstream feeder for the PVR VQ codebook cache.
- When the cache raises codebook_wait, this block burst-reads the 256-entry, 64-bit VQ codebook (2 KB at the start of a VQ texture) from VRAM.
- Each returned word is presented to the cache with a one-cycle valid strobe.
- It sits between the texture-parameter stage, which supplies the codebook base, and the VRAM arbiter read port.

Parameters:
- BURST_LEN, 8, 64-bit words per VRAM burst request. Must be a power of two dividing 256.
- ADDR_W, 20, VRAM 64-bit word address width (8 MB VRAM).

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- cb_base  in  ADDR_W  codebook base, as a 64-bit word address. Sampled on fetch start.
- codebook_wait  in  1  cache requests a codebook fill. High until 256 words are accepted.
- ram_read_offset  in  8  word index the cache expects next.
- cache_vram_valid  out  1  one-cycle strobe: cache_din holds a codebook word.
- cache_din  out  64  codebook word to the cache.
- vram_rd  out  1  burst read request to the arbiter.
- vram_addr  out  ADDR_W  burst start word address.
- vram_ack  in  1  arbiter accepted the request this cycle.
- vram_rvalid  in  1  VRAM read data beat valid.
- vram_rdata  in  64  VRAM read data.
- fetch_busy  out  1  high from fetch start through DONE/DRAIN.
- seq_error  out  1  sticky: a beat was delivered while ram_read_offset differed from the internal word count.

Behaviour:
Reset:
- All outputs are 0.
- State is IDLE; word counter is 0; beat counter is 0.

State machine:
- IDLE:
  - Exit when codebook_wait=1: latch cb_base into base_r, set wcnt=0, go to REQ.
  - fetch_busy goes high the cycle after entry to REQ.
- REQ:
  - vram_rd=1, with vram_addr = base_r + wcnt, truncated mod 2^ADDR_W so the address wraps silently.
  - Hold vram_rd and vram_addr stable until vram_ack.
  - On vram_ack: vram_rd=0 next cycle, beat counter cleared, go to DATA.
  - If codebook_wait falls before ack: drop vram_rd and go to IDLE (no burst outstanding).
- DATA:
  - Each vram_rvalid beat drives, registered with 1-cycle latency:
    - cache_vram_valid=1;
    - cache_din=vram_rdata;
    - wcnt += 1;
    - beat counter += 1.
  - After beat BURST_LEN:
    - if wcnt (9-bit) == 256, go to DONE;
    - otherwise go to REQ.
  - Exactly one burst is outstanding at a time.
  - If codebook_wait falls mid-burst, go to DRAIN.
- DRAIN:
  - Consume the remaining beats of the current burst with cache_vram_valid held 0.
  - When the beat count reaches BURST_LEN, go to IDLE.
- DONE:
  - Wait for codebook_wait=0, then go to IDLE.
  - If codebook_wait is still high 2 cycles after the last beat, stay in DONE and do not refetch.
  - A new rising request re-enters from IDLE.

Sequence check and strobes:
- seq_error is set when a beat strobe is issued and ram_read_offset != wcnt[7:0] (pre-increment).
- seq_error clears only on reset.
- cache_vram_valid is never asserted outside DATA.
- vram_rvalid outside DATA/DRAIN is ignored.

Simultaneous events and arithmetic:
- A final-beat vram_rvalid arriving in the same cycle codebook_wait falls is still delivered. DONE/IDLE resolves on the next cycle.
- Reset mid-burst returns to IDLE immediately. Late VRAM beats after reset are ignored because state is IDLE.
- wcnt is 9 bits; bit 8 marks completion. The address adder uses wcnt zero-extended to ADDR_W.

Test Plan:
- Basic fill:
  - Stimulus: cb_base=0x01000; codebook_wait held high; vram_ack 1 cycle after each request; 8 rvalid beats with data = address.
  - Response: 32 requests at 0x01000, 0x01008 … 0x010F8; 256 strobes with cache_din=0x1000..0x10FF; DONE reached; seq_error=0.
- Backpressure:
  - Stimulus: vram_ack delayed 5 cycles; rvalid beats gapped (alternate cycles).
  - Response: vram_rd and vram_addr stable until ack; strobe count is still 256 with no duplicates.
- Abort:
  - Stimulus: codebook_wait falls after beat 3 of burst 2 (wcnt=11).
  - Response: remaining 5 beats swallowed (no strobes); state IDLE; a new request restarts at wcnt=0 with fresh cb_base=0x02000.
- Address wrap:
  - Stimulus: cb_base=0xFFFF8.
  - Response: second request at 0x00000; fill completes.
- Sequence error:
  - Stimulus: drive ram_read_offset=5 while wcnt=4 at a beat.
  - Response: seq_error=1 from the next cycle and stays set after the fill completes.
- Reset mid-op:
  - Stimulus: reset_n low during DATA, then stray rvalid beats after release.
  - Response: all outputs 0; no strobes; IDLE until codebook_wait rises.
